// File: rtl/sw_cmd_conditioner_if.sv
// Command handshake bundle between the switch conditioner (master) and the
// processor-side consumer (slave). The command is transferred on any rising
// edge where cmd_valid and cmd_ready are both high.
interface sw_cmd_conditioner_if;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;

    modport master (
        output cmd_data,
        output cmd_valid,
        input  cmd_ready
    );

    modport slave (
        input  cmd_data,
        input  cmd_valid,
        output cmd_ready
    );
endinterface

// File: rtl/sw_cmd_conditioner.sv
// Switch conditioner: 2-flop synchronizer per bit, whole-vector debounce and
// press/release detection. Every press (0 -> stable nonzero) yields exactly
// one command on a valid/ready handshake. Presses that cannot be delivered
// are reported on a sticky overflow flag rather than queued.
module sw_cmd_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 20
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [7:0]                   SW_raw,
    sw_cmd_conditioner_if.master         cmd,
    output logic [7:0]                   sw_stable,
    output logic                         ovf,
    input  logic                         ovf_clr,
    output logic [7:0]                   cmd_count
);

    // Counter value at which the candidate has been seen often enough.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        VALID    = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    logic [7:0]       sync_vec;
    logic [7:0]       cand_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [7:0]       stable_reg;
    logic             commit;
    logic [7:0]       stable_next;
    logic             press_drop;

    state_t           state_reg;
    logic [7:0]       data_reg;
    logic             valid_reg;
    logic [7:0]       count_reg;
    logic             ovf_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;

            // Two-flop synchronizer for one raw switch bit.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= SW_raw[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign sync_vec[gi] = sync_reg;
        end
    endgenerate

    // A commit happens when the candidate has survived the full window and
    // differs from what is currently published.
    assign commit      = (sync_vec == cand_reg) && !(cnt_reg < CNT_LAST) &&
                         (cand_reg != stable_reg);
    assign stable_next = commit ? cand_reg : stable_reg;

    // Any nonzero commit outside IDLE is a press nobody will ever see as a
    // command: either one is still pending, or the switches were never
    // released after the last command.
    assign press_drop  = commit && (cand_reg != 8'h00) && (state_reg != IDLE);

    // Whole-vector debounce: restart the window whenever the synchronized
    // vector changes, publish it once it has held long enough.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_reg   <= 8'h00;
            cnt_reg    <= '0;
            stable_reg <= 8'h00;
        end else if (sync_vec != cand_reg) begin
            cand_reg <= sync_vec;
            cnt_reg  <= '0;
        end else if (cnt_reg < CNT_LAST) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end else if (cand_reg != stable_reg) begin
            stable_reg <= cand_reg;
        end
    end

    // Command FSM with registered handshake outputs, transfer counter and
    // sticky overflow (a set event beats a simultaneous clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            data_reg  <= 8'h00;
            valid_reg <= 1'b0;
            count_reg <= 8'h00;
            ovf_reg   <= 1'b0;
        end else begin
            if (press_drop) begin
                ovf_reg <= 1'b1;
            end else if (ovf_clr) begin
                ovf_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (commit && (cand_reg != 8'h00)) begin
                        data_reg  <= cand_reg;
                        valid_reg <= 1'b1;
                        state_reg <= VALID;
                    end
                end
                VALID: begin
                    if (valid_reg && cmd.cmd_ready) begin
                        valid_reg <= 1'b0;
                        count_reg <= count_reg + 8'd1;
                        state_reg <= (stable_next == 8'h00) ? IDLE : WAIT_REL;
                    end
                end
                WAIT_REL: begin
                    if (commit && (cand_reg == 8'h00)) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign cmd.cmd_data  = data_reg;
    assign cmd.cmd_valid = valid_reg;
    assign sw_stable     = stable_reg;
    assign ovf           = ovf_reg;
    assign cmd_count     = count_reg;

endmodule
